// File: rtl/corevx_ptw_multilevel.sv
// ============================================================================
// Module      : corevx_ptw_multilevel
// Description : Multi-level radix page-table walker with A/D checks and abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corevx_ptw_multilevel #(
    parameter int LEVELS   = 2,
    parameter int VPN_BITS = 10,
    parameter int PPN_BITS = 22,
    parameter int PTE_LOG2 = 2,
    parameter int CHECK_AD = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 resolve_request,
    output logic                                 resolve_ack,
    input  logic [LEVELS*VPN_BITS-1:0]           virtual_address,
    input  logic                                 resolve_store,
    input  logic                                 resolve_abort,
    input  logic [PPN_BITS-1:0]                  matp_ppn,
    output logic                                 resolve_done,
    output logic                                 resolve_pagefault,
    output logic                                 resolve_accessfault,
    output logic [7:0]                           resolve_access_bits,
    output logic [PPN_BITS-1:0]                  resolve_physical_address,
    output logic                                 m_transaction,
    output logic [2:0]                           m_cmd,
    output logic [PPN_BITS+VPN_BITS+PTE_LOG2-1:0] m_address,
    input  logic [2:0]                           m_transaction_response,
    input  logic                                 m_transaction_done,
    input  logic [(8<<PTE_LOG2)-1:0]             m_rdata
);

    localparam int VA_W  = LEVELS * VPN_BITS;
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    localparam logic [2:0] c_ARMLEOBUS_CMD_NONE         = 3'd0;
    localparam logic [2:0] c_ARMLEOBUS_CMD_READ         = 3'd1;
    localparam logic [2:0] c_ARMLEOBUS_RESPONSE_SUCCESS = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WALK    = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [VA_W-1:0]     r_va;
    logic                r_store;
    logic [PPN_BITS-1:0] r_table_base;
    logic [LVL_W-1:0]    r_level;
    logic                r_pf;
    logic                r_af;
    logic [7:0]          r_bits;
    logic [PPN_BITS-1:0] r_pa;

    logic                w_accept;
    logic                w_descend;
    logic                w_finish;
    logic                w_pf_nxt;
    logic                w_af_nxt;
    logic [PPN_BITS-1:0] w_pte_ppn;
    logic [PPN_BITS-1:0] w_lo_mask;
    logic [PPN_BITS-1:0] w_va_ext;
    logic [PPN_BITS-1:0] w_pa;
    logic [VPN_BITS-1:0] w_vpn_cur;
    logic                w_misaligned;
    logic                w_unused;

    assign w_pte_ppn = m_rdata[10 +: PPN_BITS];
    assign w_vpn_cur = r_va[r_level*VPN_BITS +: VPN_BITS];
    assign w_unused  = ^m_rdata;

    generate
        if (VA_W >= PPN_BITS) begin : g_va_trunc
            assign w_va_ext = r_va[PPN_BITS-1:0];
        end else begin : g_va_pad
            assign w_va_ext = {{(PPN_BITS-VA_W){1'b0}}, r_va};
        end
    endgenerate

    // Low PPN bits that a superpage at the current level takes from the VA
    always_comb begin
        w_lo_mask = '0;
        for (int i = 0; i < PPN_BITS; i++) begin
            w_lo_mask[i] = (i < int'(r_level) * VPN_BITS);
        end
    end

    assign w_misaligned = |(w_pte_ppn & w_lo_mask);
    assign w_pa         = (w_pte_ppn & ~w_lo_mask) | (w_va_ext & w_lo_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_descend   = 1'b0;
        w_finish    = 1'b0;
        w_pf_nxt    = 1'b0;
        w_af_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (resolve_request) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WALK;
                end
            end
            S_WALK: begin
                if (resolve_abort) begin
                    w_state_nxt = m_transaction_done ? S_IDLE : S_DRAIN;
                end else if (m_transaction_done) begin
                    if (m_transaction_response != c_ARMLEOBUS_RESPONSE_SUCCESS) begin
                        w_finish = 1'b1;
                        w_af_nxt = 1'b1;
                    end else if (!m_rdata[0] || (!m_rdata[1] && m_rdata[2])) begin
                        w_finish = 1'b1;
                        w_pf_nxt = 1'b1;
                    end else if (m_rdata[1] || m_rdata[3]) begin
                        w_finish = 1'b1;
                        if (w_misaligned) begin
                            w_pf_nxt = 1'b1;
                        end else if ((CHECK_AD != 0) &&
                                     (!m_rdata[6] || (r_store && !m_rdata[7]))) begin
                            w_pf_nxt = 1'b1;
                        end
                    end else if (r_level == '0) begin
                        w_finish = 1'b1;
                        w_pf_nxt = 1'b1;
                    end else begin
                        w_descend = 1'b1;
                    end
                    if (w_finish) begin
                        w_state_nxt = S_RESPOND;
                    end
                end
            end
            S_DRAIN: begin
                if (m_transaction_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESPOND: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_va         <= '0;
            r_store      <= 1'b0;
            r_table_base <= '0;
            r_level      <= '0;
            r_pf         <= 1'b0;
            r_af         <= 1'b0;
            r_bits       <= '0;
            r_pa         <= '0;
        end else begin
            if (w_accept) begin
                r_va         <= virtual_address;
                r_store      <= resolve_store;
                r_table_base <= matp_ppn;
                r_level      <= LVL_W'(LEVELS - 1);
            end
            if (w_descend) begin
                r_table_base <= w_pte_ppn;
                r_level      <= r_level - 1'b1;
            end
            if (w_finish) begin
                r_pf   <= w_pf_nxt;
                r_af   <= w_af_nxt;
                r_bits <= (w_pf_nxt || w_af_nxt) ? 8'h00 : m_rdata[7:0];
                r_pa   <= (w_pf_nxt || w_af_nxt) ? '0 : w_pa;
            end
        end
    end

    assign resolve_ack              = (r_state == S_IDLE);
    assign resolve_done             = (r_state == S_RESPOND);
    assign resolve_pagefault        = resolve_done && r_pf;
    assign resolve_accessfault      = resolve_done && r_af;
    assign resolve_access_bits      = resolve_done ? r_bits : 8'h00;
    assign resolve_physical_address = resolve_done ? r_pa : '0;
    assign m_transaction            = (r_state == S_WALK) || (r_state == S_DRAIN);
    assign m_cmd                    = m_transaction ? c_ARMLEOBUS_CMD_READ : c_ARMLEOBUS_CMD_NONE;
    assign m_address                = {r_table_base, w_vpn_cur, {PTE_LOG2{1'b0}}};

endmodule

`default_nettype wire

// File: tb/tb_corevx_ptw_multilevel.sv
// ============================================================================
// Module      : tb_corevx_ptw_multilevel
// Description : Directed self-checking bench for Sv32 and Sv39 walker configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_corevx_ptw_multilevel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Sv32 instance
    logic        req = 0, ack, store = 0, abort = 0;
    logic [19:0] va = '0;
    logic [21:0] matp = '0;
    logic        done, pf, af, mt, mdone = 0;
    logic [7:0]  bits;
    logic [21:0] pa;
    logic [2:0]  cmd, resp = '0;
    logic [33:0] maddr;
    logic [31:0] rdata = '0;

    corevx_ptw_multilevel dut (
        .clk(clk), .rst(rst),
        .resolve_request(req), .resolve_ack(ack), .virtual_address(va),
        .resolve_store(store), .resolve_abort(abort), .matp_ppn(matp),
        .resolve_done(done), .resolve_pagefault(pf), .resolve_accessfault(af),
        .resolve_access_bits(bits), .resolve_physical_address(pa),
        .m_transaction(mt), .m_cmd(cmd), .m_address(maddr),
        .m_transaction_response(resp), .m_transaction_done(mdone), .m_rdata(rdata)
    );

    // Sv39 instance
    logic        b_req = 0, b_ack, b_store = 0, b_abort = 0;
    logic [26:0] b_va = '0;
    logic [43:0] b_matp = '0;
    logic        b_done, b_pf, b_af, b_mt, b_mdone = 0;
    logic [7:0]  b_bits;
    logic [43:0] b_pa;
    logic [2:0]  b_cmd, b_resp = '0;
    logic [55:0] b_maddr;
    logic [63:0] b_rdata = '0;

    corevx_ptw_multilevel #(
        .LEVELS(3), .VPN_BITS(9), .PPN_BITS(44), .PTE_LOG2(3), .CHECK_AD(1)
    ) dut39 (
        .clk(clk), .rst(rst),
        .resolve_request(b_req), .resolve_ack(b_ack), .virtual_address(b_va),
        .resolve_store(b_store), .resolve_abort(b_abort), .matp_ppn(b_matp),
        .resolve_done(b_done), .resolve_pagefault(b_pf), .resolve_accessfault(b_af),
        .resolve_access_bits(b_bits), .resolve_physical_address(b_pa),
        .m_transaction(b_mt), .m_cmd(b_cmd), .m_address(b_maddr),
        .m_transaction_response(b_resp), .m_transaction_done(b_mdone), .m_rdata(b_rdata)
    );

    // Accept a Sv32 request (root 22'h00100), then scramble the inputs
    task automatic start(input string nm, input logic [19:0] a, input logic st, input logic ab);
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++; $display("FAIL %s ack_before_req: got %b want 1", nm, ack);
        end
        req = 1'b1; va = a; matp = 22'h00100; store = st; abort = ab;
        @(negedge clk);
        req = 1'b0; abort = 1'b0; va = '0; matp = '0; store = ~st;
    endtask

    task automatic bus_read(input string nm, input logic [33:0] ea, input logic [31:0] d,
                            input logic [2:0] r, input int lat);
        int t = 0;
        while (mt !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (mt !== 1'b1 || maddr !== ea || cmd !== 3'd1) begin
            n_fail++;
            $display("FAIL %s read_req: got mt=%b addr=%h cmd=%0d want mt=1 addr=%h cmd=1",
                     nm, mt, maddr, cmd, ea);
        end
        repeat (lat) @(negedge clk);
        n_checks++;
        if (mt !== 1'b1 || maddr !== ea || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s read_hold: got mt=%b addr=%h done=%b want mt=1 addr=%h done=0",
                     nm, mt, maddr, done, ea);
        end
        mdone = 1'b1; rdata = d; resp = r;
        @(negedge clk);
        mdone = 1'b0; rdata = '0; resp = '0;
    endtask

    task automatic expect_result(input string nm, input logic epf, input logic eaf,
                                 input logic [7:0] ebits, input logic [21:0] epa);
        n_checks++;
        if (done !== 1'b1 || pf !== epf || af !== eaf || bits !== ebits || pa !== epa) begin
            n_fail++;
            $display("FAIL %s result: got done=%b pf=%b af=%b bits=%h pa=%h want done=1 pf=%b af=%b bits=%h pa=%h",
                     nm, done, pf, af, bits, pa, epf, eaf, ebits, epa);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || ack !== 1'b1) begin
            n_fail++; $display("FAIL %s single_done: got done=%b ack=%b want done=0 ack=1", nm, done, ack);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== 1'b1 || mt !== 1'b0 || done !== 1'b0 || cmd !== 3'd0 || maddr !== '0 ||
            pf !== 1'b0 || af !== 1'b0 || bits !== 8'h00 || pa !== '0 || b_ack !== 1'b1 || b_mt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ack=%b mt=%b done=%b cmd=%0d addr=%h pf=%b af=%b bits=%h pa=%h b_ack=%b b_mt=%b want ack=1 others 0",
                     ack, mt, done, cmd, maddr, pf, af, bits, pa, b_ack, b_mt);
        end
        rst = 1'b0;
    endtask

    task automatic test_4k_hit;
        start("hit4k", 20'h12345, 1'b0, 1'b0);
        bus_read("hit4k_l1", 34'h000100120, 32'h00080001, 3'd0, 2);
        bus_read("hit4k_l0", 34'h000200D14, 32'h0EAF34C7, 3'd0, 1);
        expect_result("hit4k", 1'b0, 1'b0, 8'hC7, 22'h3ABCD);
    endtask

    task automatic test_megapage;
        start("mega", 20'h12345, 1'b0, 1'b0);
        bus_read("mega_l1", 34'h000100120, 32'h001000CB, 3'd0, 0);
        expect_result("mega", 1'b0, 1'b0, 8'hCB, 22'h000745);
        start("mega_misal", 20'h12345, 1'b0, 1'b0);
        bus_read("mega_misal_l1", 34'h000100120, 32'h001004CB, 3'd0, 0);
        expect_result("mega_misal", 1'b1, 1'b0, 8'h00, 22'h0);
    endtask

    task automatic test_faults;
        start("accfault", 20'h12345, 1'b0, 1'b0);
        bus_read("accfault_l1", 34'h000100120, 32'h00080001, 3'd0, 0);
        bus_read("accfault_l0", 34'h000200D14, 32'h0EAF34C7, 3'd3, 0);
        expect_result("accfault", 1'b0, 1'b1, 8'h00, 22'h0);

        start("invalid", 20'h12345, 1'b0, 1'b0);
        bus_read("invalid_l1", 34'h000100120, 32'h00000004, 3'd0, 0);
        expect_result("invalid", 1'b1, 1'b0, 8'h00, 22'h0);

        start("w_no_r", 20'h12345, 1'b0, 1'b0);
        bus_read("w_no_r_l1", 34'h000100120, 32'h00000005, 3'd0, 0);
        expect_result("w_no_r", 1'b1, 1'b0, 8'h00, 22'h0);

        start("ptr_l0", 20'h12345, 1'b0, 1'b0);
        bus_read("ptr_l0_l1", 34'h000100120, 32'h00080001, 3'd0, 0);
        bus_read("ptr_l0_l0", 34'h000200D14, 32'h00080001, 3'd0, 0);
        expect_result("ptr_l0", 1'b1, 1'b0, 8'h00, 22'h0);

        start("dirty_st", 20'h12345, 1'b1, 1'b0);
        bus_read("dirty_st_l1", 34'h000100120, 32'h00080001, 3'd0, 0);
        bus_read("dirty_st_l0", 34'h000200D14, 32'h0EAF3447, 3'd0, 0);
        expect_result("dirty_st", 1'b1, 1'b0, 8'h00, 22'h0);

        start("dirty_ld", 20'h12345, 1'b0, 1'b0);
        bus_read("dirty_ld_l1", 34'h000100120, 32'h00080001, 3'd0, 0);
        bus_read("dirty_ld_l0", 34'h000200D14, 32'h0EAF3447, 3'd0, 0);
        expect_result("dirty_ld", 1'b0, 1'b0, 8'h47, 22'h3ABCD);

        start("no_access", 20'h12345, 1'b0, 1'b0);
        bus_read("no_access_l1", 34'h000100120, 32'h0010008B, 3'd0, 0);
        expect_result("no_access", 1'b1, 1'b0, 8'h00, 22'h0);
    endtask

    task automatic test_abort;
        start("abort", 20'h12345, 1'b0, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (mt !== 1'b1 || ack !== 1'b0 || done !== 1'b0 || maddr !== 34'h000100120) begin
                n_fail++;
                $display("FAIL abort_drain[%0d]: got mt=%b ack=%b done=%b addr=%h want mt=1 ack=0 done=0 addr=000100120",
                         k, mt, ack, done, maddr);
            end
            if (k < 2) @(negedge clk);
        end
        mdone = 1'b1; rdata = 32'h001000CB;
        @(negedge clk);
        mdone = 1'b0; rdata = '0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (mt !== 1'b0 || ack !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle[%0d]: got mt=%b ack=%b done=%b want mt=0 ack=1 done=0", k, mt, ack, done);
            end
            @(negedge clk);
        end
        test_4k_hit();

        // abort coinciding with the read completion drops the data directly
        start("abort_same", 20'h12345, 1'b0, 1'b0);
        abort = 1'b1; mdone = 1'b1; rdata = 32'h001000CB;
        @(negedge clk);
        abort = 1'b0; mdone = 1'b0; rdata = '0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mt !== 1'b0 || ack !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_same[%0d]: got mt=%b ack=%b done=%b want mt=0 ack=1 done=0", k, mt, ack, done);
            end
            @(negedge clk);
        end

        // abort held during accept in IDLE has no effect
        start("abort_idle_ign", 20'h12345, 1'b0, 1'b1);
        bus_read("abort_idle_ign_l1", 34'h000100120, 32'h001000CB, 3'd0, 1);
        expect_result("abort_idle_ign", 1'b0, 1'b0, 8'hCB, 22'h000745);
    endtask

    task automatic test_reset_mid_walk;
        start("rst_walk", 20'h12345, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (mt !== 1'b0 || ack !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_walk: got mt=%b ack=%b done=%b want mt=0 ack=1 done=0", mt, ack, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || mt !== 1'b0) begin
            n_fail++; $display("FAIL rst_walk_after: got done=%b mt=%b want 0 0", done, mt);
        end
        start("rst_recover", 20'h12345, 1'b0, 1'b0);
        bus_read("rst_recover_l1", 34'h000100120, 32'h001000CB, 3'd0, 0);
        expect_result("rst_recover", 1'b0, 1'b0, 8'hCB, 22'h000745);
    endtask

    task automatic sv39_walk(input string nm, input int nreads, input logic [63:0] leaf,
                             input logic epf, input logic [7:0] ebits, input logic [43:0] epa);
        logic [55:0] ea [3];
        logic [63:0] pd [3];
        ea[0] = 56'h1008;  ea[1] = 56'h10010; ea[2] = 56'h20018;
        pd[0] = 64'h4001;  pd[1] = 64'h8001;  pd[2] = 64'h0;
        pd[nreads-1] = leaf;
        @(negedge clk);
        b_req = 1'b1; b_va = 27'h0040403; b_matp = 44'h1;
        @(negedge clk);
        b_req = 1'b0; b_va = '0; b_matp = '0;
        for (int k = 0; k < nreads; k++) begin
            int t = 0;
            while (b_mt !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            n_checks++;
            if (b_mt !== 1'b1 || b_maddr !== ea[k] || b_cmd !== 3'd1) begin
                n_fail++;
                $display("FAIL %s read%0d: got mt=%b addr=%h cmd=%0d want mt=1 addr=%h cmd=1",
                         nm, k, b_mt, b_maddr, b_cmd, ea[k]);
            end
            b_mdone = 1'b1; b_rdata = pd[k];
            @(negedge clk);
            b_mdone = 1'b0; b_rdata = '0;
        end
        n_checks++;
        if (b_done !== 1'b1 || b_pf !== epf || b_af !== 1'b0 || b_bits !== ebits || b_pa !== epa) begin
            n_fail++;
            $display("FAIL %s result: got done=%b pf=%b af=%b bits=%h pa=%h want done=1 pf=%b af=0 bits=%h pa=%h",
                     nm, b_done, b_pf, b_af, b_bits, b_pa, epf, ebits, epa);
        end
        @(negedge clk);
    endtask

    task automatic test_sv39;
        sv39_walk("sv39_3lvl", 3, (64'hABCDE << 10) | 64'hCF, 1'b0, 8'hCF, 44'hABCDE);
        sv39_walk("sv39_giga_misal", 1, (64'h40001 << 10) | 64'hCF, 1'b1, 8'h00, 44'h0);
        sv39_walk("sv39_giga_ok", 1, (64'h40000 << 10) | 64'hCF, 1'b0, 8'hCF, 44'h40403);
    endtask

    initial begin
        test_reset();
        test_4k_hit();
        test_megapage();
        test_faults();
        test_abort();
        test_reset_mid_walk();
        test_sv39();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
